// File: rtl/pipe_pkg.sv
// Shared widths, defaults and forwarding-select encodings for the
// EX/MEM/WB back end of the pipeline.
package pipe_pkg;

    localparam int XLEN         = 32;
    localparam int REG_W        = 5;
    localparam int MAX_WAIT_DEF = 15;

    // Operand source chosen by the forwarding unit.
    typedef enum logic [1:0] {
        FWD_SEL_IDEX = 2'b00,
        FWD_SEL_MEM  = 2'b01,
        FWD_SEL_WB   = 2'b10
    } fwd_sel_e;

    // Control half of the EX/MEM register.
    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             rf_le;
        logic             load;
        logic             store;
    } mem_ctrl_t;

endpackage

// File: rtl/mem_wait_ctr.sv
// Counts wait cycles of the access held in MEM, raises timeout on the last
// allowed cycle and keeps a sticky bus-error flag until reset.
module mem_wait_ctr
    import pipe_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic memop,
    input  logic dmem_ready,
    output logic timeout,
    output logic MEM_ERR
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic             timeout_c;

    always_comb begin
        timeout_c  = (wait_cnt_q == CNT_W'(MAX_WAIT)) & memop & ~dmem_ready;
        wait_cnt_d = '0;
        // Count only genuinely stalled cycles; completion, timeout and idle clear.
        if (memop & ~dmem_ready & ~timeout_c) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
        mem_err_d  = mem_err_q | timeout_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign timeout = timeout_c;
    assign MEM_ERR = mem_err_q;

endmodule

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with the data-memory handshake,
// EX stall generation and the MEM/WB forwarding taps.
module ex_mem_wb_pipe
    import pipe_pkg::*;
#(
    parameter int XLEN     = pipe_pkg::XLEN,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] RD_EX,
    input  logic             RF_LE_EX,
    input  logic             LOAD_EX,
    input  logic             STORE_EX,
    input  logic [XLEN-1:0]  ALU_EX,
    input  logic [XLEN-1:0]  SDATA_EX,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [XLEN-1:0]  dmem_wdata,
    input  logic [XLEN-1:0]  dmem_rdata,
    input  logic             dmem_ready,
    output logic             STALL_EX,
    output logic [REG_W-1:0] RD_MEM,
    output logic             RF_LE_MEM,
    output logic             LOAD_MEM,
    output logic [XLEN-1:0]  FWD_MEM,
    output logic [REG_W-1:0] RD_WB,
    output logic             RF_LE_WB,
    output logic [XLEN-1:0]  FWD_WB,
    output logic             MEM_ERR
);

    mem_ctrl_t        ctrl_mem_q, ctrl_mem_d;
    logic [XLEN-1:0]  alu_mem_q, alu_mem_d;
    logic [XLEN-1:0]  sdata_mem_q, sdata_mem_d;
    logic [REG_W-1:0] rd_wb_q, rd_wb_d;
    logic             rf_le_wb_q, rf_le_wb_d;
    logic [XLEN-1:0]  fwd_wb_q, fwd_wb_d;

    logic memop;
    logic timeout;
    logic mem_stall;

    assign memop     = ctrl_mem_q.load | ctrl_mem_q.store;
    assign mem_stall = memop & ~dmem_ready & ~timeout;

    mem_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .clk        (clk),
        .rst        (rst),
        .memop      (memop),
        .dmem_ready (dmem_ready),
        .timeout    (timeout),
        .MEM_ERR    (MEM_ERR)
    );

    always_comb begin
        ctrl_mem_d  = ctrl_mem_q;
        alu_mem_d   = alu_mem_q;
        sdata_mem_d = sdata_mem_q;
        rd_wb_d     = rd_wb_q;
        fwd_wb_d    = fwd_wb_q;
        rf_le_wb_d  = 1'b0;
        if (!mem_stall) begin
            ctrl_mem_d.rd    = RD_EX;
            ctrl_mem_d.rf_le = RF_LE_EX;
            ctrl_mem_d.load  = LOAD_EX;
            // A load+store encoding is illegal; it is executed as a load.
            ctrl_mem_d.store = STORE_EX & ~LOAD_EX;
            alu_mem_d        = ALU_EX;
            sdata_mem_d      = SDATA_EX;
            rd_wb_d          = ctrl_mem_q.rd;
            rf_le_wb_d       = ctrl_mem_q.rf_le & ~ctrl_mem_q.store & ~timeout;
            fwd_wb_d         = ctrl_mem_q.load ? dmem_rdata : alu_mem_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_mem_q  <= '0;
            alu_mem_q   <= '0;
            sdata_mem_q <= '0;
            rd_wb_q     <= '0;
            rf_le_wb_q  <= 1'b0;
            fwd_wb_q    <= '0;
        end else begin
            ctrl_mem_q  <= ctrl_mem_d;
            alu_mem_q   <= alu_mem_d;
            sdata_mem_q <= sdata_mem_d;
            rd_wb_q     <= rd_wb_d;
            rf_le_wb_q  <= rf_le_wb_d;
            fwd_wb_q    <= fwd_wb_d;
        end
    end

    // Request is masked during reset so an abandoned access never reaches memory.
    assign dmem_req   = memop & ~rst;
    assign dmem_we    = ctrl_mem_q.store;
    assign dmem_addr  = alu_mem_q;
    assign dmem_wdata = sdata_mem_q;
    assign STALL_EX   = mem_stall;

    assign RD_MEM     = ctrl_mem_q.rd;
    assign RF_LE_MEM  = ctrl_mem_q.rf_le;
    assign LOAD_MEM   = ctrl_mem_q.load;
    assign FWD_MEM    = alu_mem_q;
    assign RD_WB      = rd_wb_q;
    assign RF_LE_WB   = rf_le_wb_q;
    assign FWD_WB     = fwd_wb_q;

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Directed bench for ex_mem_wb_pipe: every register-file write is predicted
// when the instruction is issued and matched when it appears in WB.
module tb_ex_mem_wb_pipe;

    localparam int W = 37;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  RD_EX = '0;
    logic        RF_LE_EX = 1'b0;
    logic        LOAD_EX = 1'b0;
    logic        STORE_EX = 1'b0;
    logic [31:0] ALU_EX = '0;
    logic [31:0] SDATA_EX = '0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ready = 1'b1;
    logic        STALL_EX;
    logic [4:0]  RD_MEM, RD_WB;
    logic        RF_LE_MEM, LOAD_MEM, RF_LE_WB, MEM_ERR;
    logic [31:0] FWD_MEM, FWD_WB;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] want;
    int pass_cnt  = 0;
    int total_cnt = 0;

    ex_mem_wb_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .RD_EX      (RD_EX),
        .RF_LE_EX   (RF_LE_EX),
        .LOAD_EX    (LOAD_EX),
        .STORE_EX   (STORE_EX),
        .ALU_EX     (ALU_EX),
        .SDATA_EX   (SDATA_EX),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .STALL_EX   (STALL_EX),
        .RD_MEM     (RD_MEM),
        .RF_LE_MEM  (RF_LE_MEM),
        .LOAD_MEM   (LOAD_MEM),
        .FWD_MEM    (FWD_MEM),
        .RD_WB      (RD_WB),
        .RF_LE_WB   (RF_LE_WB),
        .FWD_WB     (FWD_WB),
        .MEM_ERR    (MEM_ERR)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic [4:0] rd, input logic le, input logic ld,
                            input logic st, input logic [31:0] alu, input logic [31:0] sd);
        RD_EX    = rd;
        RF_LE_EX = le;
        LOAD_EX  = ld;
        STORE_EX = st;
        ALU_EX   = alu;
        SDATA_EX = sd;
    endtask

    task automatic bubble();
        drive_ex(5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // scoreboard: match every register-file write against the prediction queue
    always @(negedge clk) begin
        if (!rst && RF_LE_WB) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra_wb", 160'(RF_LE_WB), 160'd0);
            end else begin
                want = exp_q.pop_front();
                chk("sb_wb", 160'({RD_WB, FWD_WB}), 160'(want));
            end
        end
    end

    initial begin
        logic [4:0]  r_rd;
        logic        r_le;
        logic [31:0] r_val;

        // reset state
        tick();
        tick();
        chk("rst_all", 160'({dmem_req, dmem_we, dmem_addr, dmem_wdata, STALL_EX, RD_MEM,
                             RF_LE_MEM, LOAD_MEM, FWD_MEM, RD_WB, RF_LE_WB, FWD_WB, MEM_ERR}),
            160'd0);
        rst = 1'b0;

        // ALU chain
        tick();
        drive_ex(5'd5, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        exp_q.push_back({5'd5, 32'h10});
        #1;
        chk("alu_stall0", 160'(STALL_EX), 160'd0);
        tick();
        bubble();
        #1;
        chk("alu_mem", 160'({RD_MEM, RF_LE_MEM, LOAD_MEM, FWD_MEM, dmem_req}),
            160'({5'd5, 1'b1, 1'b0, 32'h10, 1'b0}));
        chk("alu_stall1", 160'(STALL_EX), 160'd0);
        tick();
        chk("alu_wb", 160'({RD_WB, RF_LE_WB, FWD_WB}), 160'({5'd5, 1'b1, 32'h10}));

        // zero-wait load
        drive_ex(5'd7, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
        dmem_ready = 1'b1;
        dmem_rdata = 32'hCAFE;
        exp_q.push_back({5'd7, 32'hCAFE});
        tick();
        bubble();
        #1;
        chk("zw_mem", 160'({LOAD_MEM, dmem_req, dmem_we, dmem_addr, STALL_EX}),
            160'({1'b1, 1'b1, 1'b0, 32'h100, 1'b0}));
        tick();
        chk("zw_wb", 160'({LOAD_MEM, RD_WB, RF_LE_WB, FWD_WB}),
            160'({1'b0, 5'd7, 1'b1, 32'hCAFE}));

        // random ALU burst, x0 destinations included
        for (int i = 0; i < 10; i++) begin
            r_rd  = 5'($urandom_range(0, 31));
            r_le  = 1'($urandom_range(0, 1));
            r_val = $urandom;
            drive_ex(r_rd, r_le, 1'b0, 1'b0, r_val, 32'h0);
            if (r_le) exp_q.push_back({r_rd, r_val});
            tick();
        end
        bubble();
        tick();
        tick();

        // store with three wait states, ALU op held behind it
        drive_ex(5'd9, 1'b1, 1'b0, 1'b1, 32'h20, 32'h55);
        dmem_ready = 1'b0;
        tick();
        drive_ex(5'd10, 1'b1, 1'b0, 1'b0, 32'hAB, 32'h0);
        exp_q.push_back({5'd10, 32'hAB});
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_wait", 160'({STALL_EX, dmem_req, dmem_we, dmem_addr, dmem_wdata, RF_LE_WB}),
                160'({1'b1, 1'b1, 1'b1, 32'h20, 32'h55, 1'b0}));
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        chk("st_done", 160'({STALL_EX, dmem_req}), 160'({1'b0, 1'b1}));
        tick();
        bubble();
        #1;
        chk("st_adv", 160'({RD_MEM, dmem_req, RF_LE_WB}), 160'({5'd10, 1'b0, 1'b0}));
        tick();
        tick();

        // load that never completes: bus timeout
        drive_ex(5'd11, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
        dmem_ready = 1'b0;
        tick();
        bubble();
        for (int i = 0; i < 15; i++) begin
            #1;
            chk("to_stall", 160'({STALL_EX, MEM_ERR, RF_LE_WB}), 160'({1'b1, 1'b0, 1'b0}));
            tick();
        end
        #1;
        chk("to_limit", 160'({STALL_EX, dmem_req, MEM_ERR}), 160'({1'b0, 1'b1, 1'b0}));
        tick();
        chk("to_err", 160'({MEM_ERR, LOAD_MEM, RF_LE_WB}), 160'({1'b1, 1'b0, 1'b0}));
        dmem_ready = 1'b1;
        drive_ex(5'd6, 1'b1, 1'b0, 1'b0, 32'h66, 32'h0);
        exp_q.push_back({5'd6, 32'h66});
        tick();
        bubble();
        tick();
        tick();
        chk("to_sticky", 160'(MEM_ERR), 160'd1);

        // reset in the second wait cycle of a load
        drive_ex(5'd12, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0);
        dmem_ready = 1'b0;
        tick();
        bubble();
        #1;
        chk("rs_stall", 160'(STALL_EX), 160'd1);
        tick();
        rst = 1'b1;
        #1;
        chk("rs_req_gate", 160'(dmem_req), 160'd0);
        tick();
        chk("rs_all", 160'({dmem_req, dmem_we, dmem_addr, dmem_wdata, STALL_EX, RD_MEM,
                            RF_LE_MEM, LOAD_MEM, FWD_MEM, RD_WB, RF_LE_WB, FWD_WB, MEM_ERR}),
            160'd0);
        rst = 1'b0;
        dmem_ready = 1'b1;
        drive_ex(5'd13, 1'b1, 1'b0, 1'b0, 32'h77, 32'h0);
        exp_q.push_back({5'd13, 32'h77});
        tick();
        bubble();
        chk("rs_mem", 160'({RD_MEM, RF_LE_MEM, FWD_MEM}), 160'({5'd13, 1'b1, 32'h77}));
        tick();
        chk("rs_wb", 160'({RD_WB, RF_LE_WB, FWD_WB}), 160'({5'd13, 1'b1, 32'h77}));

        // ready arrives exactly at the wait limit
        drive_ex(5'd14, 1'b1, 1'b1, 1'b0, 32'h90, 32'h0);
        dmem_ready = 1'b0;
        dmem_rdata = 32'hBEEF;
        exp_q.push_back({5'd14, 32'hBEEF});
        tick();
        bubble();
        for (int i = 0; i < 15; i++) tick();
        dmem_ready = 1'b1;
        #1;
        chk("lim_nostall", 160'({STALL_EX, dmem_req}), 160'({1'b0, 1'b1}));
        tick();
        chk("lim_wb", 160'({MEM_ERR, RD_WB, RF_LE_WB, FWD_WB}),
            160'({1'b0, 5'd14, 1'b1, 32'hBEEF}));

        // load and store both asserted behaves as a load
        drive_ex(5'd15, 1'b1, 1'b1, 1'b1, 32'hA0, 32'h33);
        dmem_rdata = 32'h1234;
        exp_q.push_back({5'd15, 32'h1234});
        tick();
        bubble();
        #1;
        chk("ls_as_load", 160'({dmem_req, dmem_we, LOAD_MEM}), 160'(3'b101));
        tick();
        tick();
        tick();

        // final report
        chk("sb_drain", 160'(exp_q.size()), 160'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ex_mem_wb_pipe.md
Name: ex_mem_wb_pipe

Overview:
- Holds the EX/MEM and MEM/WB pipeline registers and drives the data-memory handshake.
- Produces RD_MEM, RF_LE_MEM, RD_WB and RF_LE_WB for the forwarding unit, plus the two forward values (MEM-stage ALU result, WB-stage write data).
- Stalls EX while a memory access waits on a slow memory.
- Flags load-in-MEM so the hazard logic can insert a bubble, because a load value cannot be forwarded from MEM.

Parameters:
- XLEN, 32, datapath width.
- MAX_WAIT, 15, largest number of stall cycles allowed for one memory access; a longer wait is a bus error.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- RD_EX  in  5  destination register of the EX instruction
- RF_LE_EX  in  1  register-file write enable of the EX instruction
- LOAD_EX  in  1  EX instruction is a load
- STORE_EX  in  1  EX instruction is a store
- ALU_EX  in  XLEN  ALU result (address for loads and stores)
- SDATA_EX  in  XLEN  store data
- dmem_req  out  1  memory request, held high until accepted
- dmem_we  out  1  write strobe qualifying dmem_req
- dmem_addr  out  XLEN  memory address
- dmem_wdata  out  XLEN  store data
- dmem_rdata  in  XLEN  load data, valid when dmem_ready=1
- dmem_ready  in  1  memory accepts or completes the access this cycle
- STALL_EX  out  1  hold PC, IF/ID and ID/EX this cycle
- RD_MEM  out  5  MEM-stage destination
- RF_LE_MEM  out  1  MEM-stage write enable
- LOAD_MEM  out  1  MEM-stage instruction is a load
- FWD_MEM  out  XLEN  MEM-stage ALU result
- RD_WB  out  5  WB-stage destination
- RF_LE_WB  out  1  WB-stage write enable, also the register-file write enable
- FWD_WB  out  XLEN  WB write data, also the register-file write data
- MEM_ERR  out  1  sticky bus-timeout flag

Behaviour:
- **Reset:** every register clears to 0. All outputs read 0 the cycle after rst is sampled high, and dmem_req stays 0 while rst is high. A reset during an outstanding access abandons it with no writeback.
- **MEM register:** memop = LOAD_MEM | STORE_MEM.
  - mem_stall = memop & ~dmem_ready & ~timeout.
  - If mem_stall=0, the MEM register loads all EX inputs on the clock edge.
  - If mem_stall=1, the MEM register holds its value.
- **STALL_EX:** STALL_EX = mem_stall, combinational. Upstream keeps the EX inputs stable while it is high.
- **Memory handshake:**
  - dmem_req = memop; dmem_we = STORE_MEM; dmem_addr = FWD_MEM; dmem_wdata = SDATA_MEM.
  - The access completes in the cycle where dmem_ready=1. Zero-wait (ready in the first cycle) costs no stall.
- **WB register:**
  - On the completing cycle, or any non-stalled cycle: RD_WB <= RD_MEM; RF_LE_WB <= RF_LE_MEM & ~STORE_MEM & ~timeout.
  - FWD_WB <= dmem_rdata if LOAD_MEM, otherwise FWD_MEM.
  - While mem_stall=1, a bubble enters WB: RF_LE_WB <= 0, and RD_WB and FWD_WB hold.
  - Result latency from EX to register-file write is 2 cycles plus wait cycles.
- **Wait counter:** 4-bit wait_cnt, sized to ceil(log2(MAX_WAIT+1)).
  - Increments each mem_stall cycle and clears to 0 on completion or on any non-memop cycle.
  - timeout = (wait_cnt == MAX_WAIT) & memop & ~dmem_ready.
  - On timeout the access is treated as complete, no register write happens, and MEM_ERR <= 1. MEM_ERR stays 1 until rst.
- **x0 destination:** RD=0 passes through unchanged; the forwarding unit and register file ignore x0.
- **Simultaneous events:**
  - dmem_ready and timeout in the same cycle: dmem_ready wins, the write is normal, no error.
  - LOAD_EX and STORE_EX both high is illegal and is treated as a load.
- **No flush input:** ID/EX bubbles arrive with RF_LE_EX=0 and LOAD_EX=STORE_EX=0.

Decomposition:
- **Shared package (pipe_pkg):** XLEN, REG_W=5, MAX_WAIT default, and the forwarding-select encodings 2'b00 (ID/EX), 2'b01 (MEM), 2'b10 (WB).
- **One sub-module, mem_wait_ctr:** contains the wait counter, the timeout compare and sticky MEM_ERR. Inputs: clk, rst, memop, dmem_ready. Outputs: timeout, MEM_ERR.

Test Plan:
- **ALU chain:** RD_EX=5, RF_LE_EX=1, ALU_EX=0x10, no memop -> cycle+1: RD_MEM=5, RF_LE_MEM=1, FWD_MEM=0x10. Cycle+2: RD_WB=5, RF_LE_WB=1, FWD_WB=0x10. STALL_EX=0 throughout.
- **Zero-wait load:** LOAD_EX=1, RD_EX=7, ALU_EX=0x100, dmem_ready=1 with rdata=0xCAFE -> LOAD_MEM=1 for 1 cycle, dmem_req=1 with addr=0x100, next cycle FWD_WB=0xCAFE, RF_LE_WB=1, no stall.
- **Wait states on a store:** STORE_EX=1, ALU_EX=0x20, SDATA_EX=0x55, dmem_ready low for 3 cycles -> STALL_EX=1 for exactly 3 cycles, dmem_we=1 and dmem_wdata=0x55 held, RF_LE_WB=0 throughout, MEM advances on the 4th cycle.
- **Timeout:** load with dmem_ready held at 0 -> STALL_EX=1 for MAX_WAIT=15 cycles, then MEM_ERR=1, RF_LE_WB stays 0, the pipeline advances, and MEM_ERR stays 1 until rst.
- **Reset during stall:** assert rst in the 2nd wait cycle of a load -> next cycle all outputs 0 and dmem_req=0. After rst drops, a fresh ALU op flows with 2-cycle latency.
- **Ready at the limit:** dmem_ready=1 in the same cycle that wait_cnt==MAX_WAIT -> normal writeback of rdata, MEM_ERR remains 0.
